// File: rtl/strobe_period_monitor_if.sv
// Strobe-monitor bus: stimulus/control toward the monitor, status back out.
interface strobe_period_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
);
    logic             enable;
    logic             strobe_i;
    logic             err_clr;
    logic             locked;
    logic [CNT_W-1:0] period_o;
    logic             period_vld;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state_o;

    modport master (
        output enable, strobe_i, err_clr,
        input  locked, period_o, period_vld, err_pulse, err_count, state_o
    );

    modport slave (
        input  enable, strobe_i, err_clr,
        output locked, period_o, period_vld, err_pulse, err_count, state_o
    );
endinterface

// File: rtl/strobe_period_monitor.sv
// Strobe period monitor: measures gaps between single-cycle strobes, locks
// after LOCK_COUNT consecutive periods of EXP_PERIOD, then flags early or
// missing strobes and keeps a saturating error count.
module strobe_period_monitor #(
    parameter int EXP_PERIOD = 3,
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    strobe_period_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_PERIOD);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [3:0]       LOCK_M  = 4'(LOCK_COUNT);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_vld_q, period_vld_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             locked_q, locked_d;
    logic [3:0]       match_inc;

    assign match_inc = match_cnt_q + 4'd1;

    // State, counters and all registered outputs; async reset to idle values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            match_cnt_q  <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_cnt_q  <= match_cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            locked_q     <= locked_d;
        end
    end

    // Next-state, gap counting, period reporting and error detection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        match_cnt_d  = match_cnt_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        err_pulse_d  = 1'b0;

        if (!bus.enable) begin
            // Disable wins over any strobe; measurement results are kept.
            state_d     = IDLE;
            cnt_d       = '0;
            match_cnt_d = '0;
        end else begin
            cnt_d = bus.strobe_i ? CNT_W'(1) : sat_inc_cnt(cnt_q);
            case (state_q)
                IDLE: begin
                    state_d     = SEARCH;
                    cnt_d       = '0;
                    match_cnt_d = '0;
                end
                SEARCH: begin
                    // First strobe only sets the reference point.
                    if (bus.strobe_i) begin
                        state_d     = TRACK;
                        match_cnt_d = '0;
                    end
                end
                TRACK: begin
                    if (bus.strobe_i) begin
                        period_d     = cnt_q;
                        period_vld_d = 1'b1;
                        if (cnt_q == EXP_CNT) begin
                            match_cnt_d = match_inc;
                            if (match_inc == LOCK_M) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            match_cnt_d = '0;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // Strobe stream lost; start over from a fresh reference.
                        state_d     = SEARCH;
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (bus.strobe_i) begin
                        period_d     = cnt_q;
                        period_vld_d = 1'b1;
                        if (cnt_q < EXP_CNT) begin
                            // Early strobe: it becomes the new reference.
                            err_pulse_d = 1'b1;
                            state_d     = TRACK;
                            match_cnt_d = '0;
                        end
                    end else if (cnt_q >= EXP_CNT) begin
                        // Expected slot passed without a strobe.
                        err_pulse_d = 1'b1;
                        state_d     = SEARCH;
                        match_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (bus.err_clr) begin
            err_count_d = '0;
        end else if (err_pulse_d) begin
            err_count_d = sat_inc_err(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end

        locked_d = (state_d == LOCKED);
    end

    assign bus.locked     = locked_q;
    assign bus.period_o   = period_q;
    assign bus.period_vld = period_vld_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_strobe_period_monitor.sv
// Directed bench for strobe_period_monitor with EXP_PERIOD=3, LOCK_COUNT=4,
// CNT_W=8, ERR_W=2.
module tb_strobe_period_monitor;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    strobe_period_monitor_if #(.CNT_W(8), .ERR_W(2)) bus ();

    strobe_period_monitor #(
        .EXP_PERIOD(3),
        .CNT_W     (8),
        .LOCK_COUNT(4),
        .ERR_W     (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive strobe for one clock edge; outputs are sampled 1 ns after the edge.
    task automatic tick(input logic s);
        bus.strobe_i = s;
        @(posedge clk);
        #1;
    endtask

    // Two idle cycles then a strobe: one ideal /3 period.
    task automatic drive_period();
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.err_clr = 1'b0;
        bus.strobe_i = 1'b0;
        tick(1'b0);
        tick(1'b0);
        tests++;
        if ({bus.state_o, bus.locked, bus.period_o, bus.period_vld, bus.err_pulse, bus.err_count} !== 15'd0) begin
            fails++;
            $display("FAIL reset_state: state=%0d locked=%0b period=%0d vld=%0b errp=%0b errcnt=%0d required all 0",
                     bus.state_o, bus.locked, bus.period_o, bus.period_vld, bus.err_pulse, bus.err_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_ideal();
        bus.enable = 1'b1;
        tick(1'b0);
        tests++;
        if (bus.state_o !== 2'd1) begin
            fails++; $display("FAIL ideal_search: state=%0d required 1", bus.state_o);
        end
        tick(1'b1);
        tests++;
        if (bus.state_o !== 2'd2 || bus.period_vld !== 1'b0) begin
            fails++; $display("FAIL ideal_reference: state=%0d vld=%0b required 2/0", bus.state_o, bus.period_vld);
        end
        for (int k = 2; k <= 5; k++) begin
            drive_period();
            tests++;
            if (bus.period_vld !== 1'b1 || bus.period_o !== 8'd3) begin
                fails++; $display("FAIL ideal_period%0d: vld=%0b period=%0d required 1/3", k, bus.period_vld, bus.period_o);
            end
            tests++;
            if (bus.locked !== (k == 5)) begin
                fails++; $display("FAIL ideal_lock%0d: locked=%0b required %0b", k, bus.locked, (k == 5));
            end
        end
    endtask

    task automatic test_missing();
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tests++;
        if (bus.err_pulse !== 1'b1 || bus.locked !== 1'b0 || bus.state_o !== 2'd1 ||
            bus.err_count !== 2'd1 || bus.period_vld !== 1'b0) begin
            fails++;
            $display("FAIL missing_err: errp=%0b locked=%0b state=%0d errcnt=%0d vld=%0b required 1/0/1/1/0",
                     bus.err_pulse, bus.locked, bus.state_o, bus.err_count, bus.period_vld);
        end
        tick(1'b0);
        tests++;
        if (bus.err_pulse !== 1'b0) begin
            fails++; $display("FAIL missing_single_pulse: errp=%0b required 0", bus.err_pulse);
        end
        tick(1'b1);
        for (int k = 2; k <= 5; k++) begin
            drive_period();
        end
        tests++;
        if (bus.locked !== 1'b1 || bus.state_o !== 2'd3) begin
            fails++; $display("FAIL missing_relock: locked=%0b state=%0d required 1/3", bus.locked, bus.state_o);
        end
    endtask

    task automatic test_early();
        tick(1'b0);
        tick(1'b1);
        tests++;
        if (bus.period_o !== 8'd2 || bus.period_vld !== 1'b1 || bus.err_pulse !== 1'b1 ||
            bus.state_o !== 2'd2 || bus.locked !== 1'b0 || bus.err_count !== 2'd2) begin
            fails++;
            $display("FAIL early_err: period=%0d vld=%0b errp=%0b state=%0d locked=%0b errcnt=%0d required 2/1/1/2/0/2",
                     bus.period_o, bus.period_vld, bus.err_pulse, bus.state_o, bus.locked, bus.err_count);
        end
        for (int k = 1; k <= 3; k++) begin
            drive_period();
        end
        tests++;
        if (bus.state_o !== 2'd2 || bus.locked !== 1'b0) begin
            fails++; $display("FAIL early_match_reset: state=%0d locked=%0b required 2/0", bus.state_o, bus.locked);
        end
        drive_period();
        tests++;
        if (bus.locked !== 1'b1) begin
            fails++; $display("FAIL early_relock: locked=%0b required 1", bus.locked);
        end
    endtask

    task automatic test_err_saturation();
        logic [1:0] exp_cnt;
        bus.err_clr = 1'b1;
        tick(1'b0);
        bus.err_clr = 1'b0;
        tests++;
        if (bus.err_count !== 2'd0) begin
            fails++; $display("FAIL errclr: errcnt=%0d required 0", bus.err_count);
        end
        for (int i = 0; i < 5; i++) begin
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            tick(1'b1);
            tests++;
            if (bus.err_pulse !== 1'b1 || bus.err_count !== exp_cnt) begin
                fails++; $display("FAIL errsat%0d: errp=%0b errcnt=%0d required 1/%0d", i, bus.err_pulse, bus.err_count, exp_cnt);
            end
            for (int k = 1; k <= 4; k++) begin
                drive_period();
            end
            tick(1'b0);
        end
        bus.err_clr = 1'b1;
        tick(1'b1);
        bus.err_clr = 1'b0;
        tests++;
        if (bus.err_pulse !== 1'b1 || bus.err_count !== 2'd0) begin
            fails++; $display("FAIL errclr_priority: errp=%0b errcnt=%0d required 1/0", bus.err_pulse, bus.err_count);
        end
        for (int k = 1; k <= 4; k++) begin
            drive_period();
        end
        tests++;
        if (bus.locked !== 1'b1) begin
            fails++; $display("FAIL errsat_relock: locked=%0b required 1", bus.locked);
        end
    endtask

    task automatic test_enable_drop();
        bus.enable = 1'b0;
        tick(1'b1);
        tests++;
        if (bus.state_o !== 2'd0 || bus.locked !== 1'b0 || bus.period_o !== 8'd3 ||
            bus.period_vld !== 1'b0 || bus.err_pulse !== 1'b0) begin
            fails++;
            $display("FAIL enable_drop: state=%0d locked=%0b period=%0d vld=%0b errp=%0b required 0/0/3/0/0",
                     bus.state_o, bus.locked, bus.period_o, bus.period_vld, bus.err_pulse);
        end
        tick(1'b0);
        bus.enable = 1'b1;
        tick(1'b0);
        tests++;
        if (bus.state_o !== 2'd1) begin
            fails++; $display("FAIL enable_search: state=%0d required 1", bus.state_o);
        end
        tick(1'b1);
        for (int k = 2; k <= 5; k++) begin
            drive_period();
        end
        tests++;
        if (bus.locked !== 1'b1) begin
            fails++; $display("FAIL enable_relock: locked=%0b required 1", bus.locked);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b0);
        tick(1'b1);
        drive_period();
        tests++;
        if (bus.state_o !== 2'd2 || bus.period_o !== 8'd3 || bus.err_count !== 2'd1) begin
            fails++; $display("FAIL pre_reset_track: state=%0d period=%0d errcnt=%0d required 2/3/1",
                              bus.state_o, bus.period_o, bus.err_count);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.state_o, bus.locked, bus.period_o, bus.period_vld, bus.err_pulse, bus.err_count} !== 15'd0) begin
            fails++;
            $display("FAIL async_reset: state=%0d locked=%0b period=%0d vld=%0b errp=%0b errcnt=%0d required all 0",
                     bus.state_o, bus.locked, bus.period_o, bus.period_vld, bus.err_pulse, bus.err_count);
        end
        #1;
        reset = 1'b0;
        tick(1'b0);
        tests++;
        if (bus.state_o !== 2'd1) begin
            fails++; $display("FAIL post_reset_search: state=%0d required 1", bus.state_o);
        end
    endtask

    task automatic test_continuous_high();
        tick(1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1);
            tests++;
            if (bus.period_vld !== 1'b1 || bus.period_o !== 8'd1 || bus.locked !== 1'b0 || bus.state_o !== 2'd2) begin
                fails++; $display("FAIL cont_high%0d: vld=%0b period=%0d locked=%0b state=%0d required 1/1/0/2",
                                  k, bus.period_vld, bus.period_o, bus.locked, bus.state_o);
            end
        end
    endtask

    task automatic test_timeout();
        repeat (254) tick(1'b0);
        tests++;
        if (bus.state_o !== 2'd2) begin
            fails++; $display("FAIL timeout_early: state=%0d required 2", bus.state_o);
        end
        tick(1'b0);
        tests++;
        if (bus.state_o !== 2'd1) begin
            fails++; $display("FAIL timeout_search: state=%0d required 1", bus.state_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_ideal();
        test_missing();
        test_early();
        test_err_saturation();
        test_enable_drop();
        test_async_reset();
        test_continuous_high();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
